// File: rtl/mips_fetch_pkg.sv
// Shared constants and encodings for the MIPS fetch stage: reset/NOP words,
// opcodes, redirect-select and FSM state encodings.
package mips_fetch_pkg;

    localparam logic [31:0] PC_RESET_DEFAULT  = 32'h0040_0000;
    localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0000;

    localparam logic [5:0] R_TYPE = 6'h00;
    localparam logic [5:0] J      = 6'h02;
    localparam logic [5:0] JAL    = 6'h03;
    localparam logic [5:0] BEQ    = 6'h04;
    localparam logic [5:0] BNE    = 6'h05;

    typedef enum logic [1:0] {
        SEQ = 2'b00,
        BR  = 2'b01,
        JMP = 2'b10,
        JR  = 2'b11
    } redirect_sel_e;

    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } fetch_state_e;

    function automatic logic [31:0] branch_target(input logic [31:0] pc4,
                                                  input logic [31:0] imm);
        return pc4 + {imm[29:0], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Signal bundle between the fetch stage and its surroundings (ID-stage
// redirect controls, instruction memory, IF/ID outputs). Perf counters
// exist only with FETCH_PERF_CNT_EN defined.
interface fetch_stage_if;
    logic        stall;
    logic        branch_eq;
    logic        branch_ne;
    logic        zero;
    logic [31:0] branch_imm;
    logic        jump;
    logic        jr;
    logic [31:0] jr_target;
    logic [31:0] imem_rdata;
    logic [31:0] imem_addr;
    logic [31:0] id_instr;
    logic [31:0] id_pc4;
    logic [5:0]  id_op;
    logic        id_valid;
    logic        misalign;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_flush_cnt;
`endif

    modport master (
        input  stall, branch_eq, branch_ne, zero, branch_imm, jump, jr,
               jr_target, imem_rdata,
        output imem_addr, id_instr, id_pc4, id_op, id_valid, misalign
`ifdef FETCH_PERF_CNT_EN
        , perf_fetch_cnt, perf_flush_cnt
`endif
    );

    modport slave (
        output stall, branch_eq, branch_ne, zero, branch_imm, jump, jr,
               jr_target, imem_rdata,
        input  imem_addr, id_instr, id_pc4, id_op, id_valid, misalign
`ifdef FETCH_PERF_CNT_EN
        , perf_fetch_cnt, perf_flush_cnt
`endif
    );

endinterface

// File: rtl/fetch_next_pc.sv
// Next-PC priority mux: JR > J/JAL > taken branch > sequential. Also flags
// a taken redirect and a misaligned redirect target.
module fetch_next_pc
    import mips_fetch_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [25:0] jump_index,
    input  logic [31:0] id_pc4,
    input  logic        id_valid,
    input  logic        stall,
    input  logic        branch_eq,
    input  logic        branch_ne,
    input  logic        zero,
    input  logic [31:0] branch_imm,
    input  logic        jump,
    input  logic        jr,
    input  logic [31:0] jr_target,
    output logic [31:0] next_pc,
    output logic        redirect,
    output logic        misalign
);

    redirect_sel_e sel;
    logic [31:0]   target;
    logic          taken_branch;

    assign taken_branch = (branch_eq & zero) | (branch_ne & ~zero);

    always_comb begin
        sel = SEQ;
        if (id_valid && !stall) begin
            if (jr)                sel = JR;
            else if (jump)         sel = JMP;
            else if (taken_branch) sel = BR;
        end
    end

    always_comb begin
        target = '0;
        case (sel)
            JR:      target = jr_target;
            JMP:     target = {id_pc4[31:28], jump_index, 2'b00};
            BR:      target = branch_target(id_pc4, branch_imm);
            default: target = '0;
        endcase
    end

    assign redirect = (sel != SEQ);
    assign misalign = redirect && (target[1:0] != 2'b00);
    // Misaligned targets are still taken, with the low bits dropped.
    assign next_pc  = redirect ? {target[31:2], 2'b00} : pc + 32'd4;

endmodule

// File: rtl/fetch_stage.sv
// MIPS instruction-fetch stage with IF/ID register and BOOT/RUN FSM.
// Optional perf counters under FETCH_PERF_CNT_EN.
module fetch_stage
    import mips_fetch_pkg::*;
#(
    parameter logic [31:0] PC_RESET  = PC_RESET_DEFAULT,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input logic           clk,
    input logic           reset,
    fetch_stage_if.master bus
);

    fetch_state_e state_q, state_d;
    logic         capture_valid;

    logic [31:0] pc_q;
    logic [31:0] instr_q;
    logic [31:0] pc4_q;
    logic        valid_q;
    logic        misalign_q;

    logic [31:0] next_pc;
    logic        redirect;
    logic        target_misaligned;

    fetch_next_pc u_next_pc (
        .pc         (pc_q),
        .jump_index (instr_q[25:0]),
        .id_pc4     (pc4_q),
        .id_valid   (valid_q),
        .stall      (bus.stall),
        .branch_eq  (bus.branch_eq),
        .branch_ne  (bus.branch_ne),
        .zero       (bus.zero),
        .branch_imm (bus.branch_imm),
        .jump       (bus.jump),
        .jr         (bus.jr),
        .jr_target  (bus.jr_target),
        .next_pc    (next_pc),
        .redirect   (redirect),
        .misalign   (target_misaligned)
    );

    always_ff @(posedge clk) begin
        if (reset) state_q <= BOOT;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d       = state_q;
        capture_valid = 1'b0;
        case (state_q)
            BOOT: begin
                state_d       = RUN;
                capture_valid = 1'b0;
            end
            RUN: begin
                state_d       = RUN;
                capture_valid = 1'b1;
            end
            default: state_d = BOOT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q       <= PC_RESET;
            instr_q    <= NOP_INSTR;
            pc4_q      <= '0;
            valid_q    <= 1'b0;
            misalign_q <= 1'b0;
        end else if (!bus.stall) begin
            pc_q       <= next_pc;
            misalign_q <= misalign_q | target_misaligned;
            if (redirect) begin
                instr_q <= NOP_INSTR;
                pc4_q   <= '0;
                valid_q <= 1'b0;
            end else begin
                instr_q <= bus.imem_rdata;
                pc4_q   <= pc_q + 32'd4;
                valid_q <= capture_valid;
            end
        end
    end

    assign bus.imem_addr = pc_q;
    assign bus.id_instr  = instr_q;
    assign bus.id_pc4    = pc4_q;
    assign bus.id_op     = instr_q[31:26];
    assign bus.id_valid  = valid_q;
    assign bus.misalign  = misalign_q;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt_q;
    logic [31:0] flush_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else if (!bus.stall) begin
            if (redirect)           flush_cnt_q <= flush_cnt_q + 32'd1;
            else if (capture_valid) fetch_cnt_q <= fetch_cnt_q + 32'd1;
        end
    end

    assign bus.perf_fetch_cnt = fetch_cnt_q;
    assign bus.perf_flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: per-scenario stimulus tables with a
// queue of expected IF-stage observations popped after each clock edge.
module tb_fetch_stage;
    import mips_fetch_pkg::*;

    typedef struct packed {
        logic        rst;
        logic        stall;
        logic        beq;
        logic        bne;
        logic        zero;
        logic        jump;
        logic        jr;
        logic [31:0] imm;
        logic [31:0] jrt;
        logic [31:0] rdata;
    } stim_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] instr;
        logic [31:0] pc4;
        logic [5:0]  op;
        logic        valid;
        logic        mis;
    } obs_t;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    obs_t exp_q[$];

    fetch_stage_if bus();

    fetch_stage #(
        .PC_RESET  (32'h0040_0000),
        .NOP_INSTR (32'h0000_0000)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic stim_t s(input logic rst, input logic st, input logic beq,
                                input logic bne, input logic z, input logic j,
                                input logic jr, input logic [31:0] imm,
                                input logic [31:0] jrt, input logic [31:0] rd);
        stim_t v;
        v = '{rst: rst, stall: st, beq: beq, bne: bne, zero: z, jump: j, jr: jr,
              imm: imm, jrt: jrt, rdata: rd};
        return v;
    endfunction

    function automatic obs_t e(input logic [31:0] addr, input logic [31:0] instr,
                               input logic [31:0] pc4, input logic valid,
                               input logic mis);
        obs_t v;
        v = '{addr: addr, instr: instr, pc4: pc4, op: instr[31:26],
              valid: valid, mis: mis};
        return v;
    endfunction

    function automatic obs_t sample();
        obs_t v;
        v = '{addr: bus.imem_addr, instr: bus.id_instr, pc4: bus.id_pc4,
              op: bus.id_op, valid: bus.id_valid, mis: bus.misalign};
        return v;
    endfunction

    task automatic apply(input stim_t v);
        reset          = v.rst;
        bus.stall      = v.stall;
        bus.branch_eq  = v.beq;
        bus.branch_ne  = v.bne;
        bus.zero       = v.zero;
        bus.jump       = v.jump;
        bus.jr         = v.jr;
        bus.branch_imm = v.imm;
        bus.jr_target  = v.jrt;
        bus.imem_rdata = v.rdata;
    endtask

    localparam logic [31:0] ADDI = 32'h2008_0005;
    localparam logic [31:0] JINS = 32'h0810_0004;
    localparam logic [31:0] BNEI = 32'h1400_0003;

    task automatic test_reset();
        stim_t st[1];
        obs_t  ex[1];
        obs_t  got, want;
        st[0] = s(1, 0, 0, 0, 0, 0, 0, 0, 0, ADDI);
        ex[0] = e(32'h0040_0000, 0, 0, 0, 0);
        for (int i = 0; i < 1; i++) begin
            apply(st[i]);
            exp_q.push_back(ex[i]);
            @(posedge clk); #1;
            want = exp_q.pop_front();
            got  = sample();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL reset[%0d] got %h expected %h", i, got, want);
            end
        end
    endtask

    task automatic test_sequential();
        stim_t st[2];
        obs_t  ex[2];
        obs_t  got, want;
        st[0] = s(0, 0, 0, 0, 0, 0, 0, 0, 0, ADDI);
        st[1] = st[0];
        ex[0] = e(32'h0040_0004, ADDI, 32'h0040_0004, 0, 0);
        ex[1] = e(32'h0040_0008, ADDI, 32'h0040_0008, 1, 0);
        for (int i = 0; i < 2; i++) begin
            apply(st[i]);
            exp_q.push_back(ex[i]);
            @(posedge clk); #1;
            want = exp_q.pop_front();
            got  = sample();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL sequential[%0d] got %h expected %h", i, got, want);
            end
        end
    endtask

    task automatic test_branch();
        stim_t st[3];
        obs_t  ex[3];
        obs_t  got, want;
        st[0] = s(0, 0, 1, 0, 1, 0, 0, 32'hFFFF_FFFE, 0, ADDI);
        st[1] = st[0];
        st[2] = s(0, 0, 0, 1, 1, 0, 0, 32'h0000_0010, 0, BNEI);
        ex[0] = e(32'h0040_0000, 0, 0, 0, 0);
        ex[1] = e(32'h0040_0004, ADDI, 32'h0040_0004, 1, 0);
        ex[2] = e(32'h0040_0008, BNEI, 32'h0040_0008, 1, 0);
        for (int i = 0; i < 3; i++) begin
            apply(st[i]);
            exp_q.push_back(ex[i]);
            @(posedge clk); #1;
            want = exp_q.pop_front();
            got  = sample();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL branch[%0d] got %h expected %h", i, got, want);
            end
        end
    endtask

    task automatic test_jump();
        stim_t st[4];
        obs_t  ex[4];
        obs_t  got, want;
        st[0] = s(0, 0, 0, 0, 0, 0, 0, 0, 0, ADDI);
        st[1] = s(0, 0, 0, 0, 0, 0, 0, 0, 0, JINS);
        st[2] = s(0, 0, 1, 0, 1, 1, 0, 32'h0000_0010, 0, JINS);
        st[3] = s(0, 0, 0, 0, 0, 0, 0, 0, 0, JINS);
        ex[0] = e(32'h0040_000C, ADDI, 32'h0040_000C, 1, 0);
        ex[1] = e(32'h0040_0010, JINS, 32'h0040_0010, 1, 0);
        ex[2] = e(32'h0040_0010, 0, 0, 0, 0);
        ex[3] = e(32'h0040_0014, JINS, 32'h0040_0014, 1, 0);
        for (int i = 0; i < 4; i++) begin
            apply(st[i]);
            exp_q.push_back(ex[i]);
            @(posedge clk); #1;
            want = exp_q.pop_front();
            got  = sample();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL jump[%0d] got %h expected %h", i, got, want);
            end
        end
    endtask

    task automatic test_stall();
        stim_t st[4];
        obs_t  ex[4];
        obs_t  got, want;
        st[0] = s(0, 1, 0, 0, 0, 1, 0, 0, 0, ADDI);
        st[1] = st[0];
        st[2] = s(0, 0, 0, 0, 0, 1, 0, 0, 0, ADDI);
        st[3] = s(0, 0, 0, 0, 0, 0, 0, 0, 0, ADDI);
        ex[0] = e(32'h0040_0014, JINS, 32'h0040_0014, 1, 0);
        ex[1] = ex[0];
        ex[2] = e(32'h0040_0010, 0, 0, 0, 0);
        ex[3] = e(32'h0040_0014, ADDI, 32'h0040_0014, 1, 0);
        for (int i = 0; i < 4; i++) begin
            apply(st[i]);
            exp_q.push_back(ex[i]);
            @(posedge clk); #1;
            want = exp_q.pop_front();
            got  = sample();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL stall[%0d] got %h expected %h", i, got, want);
            end
        end
    endtask

    task automatic test_jr_misalign();
        stim_t st[4];
        obs_t  ex[4];
        obs_t  got, want;
        st[0] = s(0, 0, 0, 0, 0, 1, 1, 0, 32'h0040_0013, ADDI);
        st[1] = s(0, 0, 0, 0, 0, 0, 0, 0, 0, ADDI);
        st[2] = st[1];
        st[3] = s(1, 1, 0, 0, 0, 1, 0, 0, 0, ADDI);
        ex[0] = e(32'h0040_0010, 0, 0, 0, 1);
        ex[1] = e(32'h0040_0014, ADDI, 32'h0040_0014, 1, 1);
        ex[2] = e(32'h0040_0018, ADDI, 32'h0040_0018, 1, 1);
        ex[3] = e(32'h0040_0000, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            apply(st[i]);
            exp_q.push_back(ex[i]);
            @(posedge clk); #1;
            want = exp_q.pop_front();
            got  = sample();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL jr_misalign[%0d] got %h expected %h", i, got, want);
            end
        end
    endtask

    task automatic test_wrap();
        stim_t st[5];
        obs_t  ex[5];
        obs_t  got, want;
        st[0] = s(0, 0, 0, 0, 0, 0, 0, 0, 0, ADDI);
        st[1] = s(0, 0, 0, 0, 0, 0, 1, 0, 32'hFFFF_FFFC, ADDI);
        st[2] = st[1];
        st[3] = s(0, 0, 0, 0, 0, 0, 0, 0, 0, ADDI);
        st[4] = s(0, 0, 0, 1, 0, 0, 0, 32'h0000_0004, 0, ADDI);
        ex[0] = e(32'h0040_0004, ADDI, 32'h0040_0004, 0, 0);
        ex[1] = e(32'h0040_0008, ADDI, 32'h0040_0008, 1, 0);
        ex[2] = e(32'hFFFF_FFFC, 0, 0, 0, 0);
        ex[3] = e(32'h0000_0000, ADDI, 32'h0000_0000, 1, 0);
        ex[4] = e(32'h0000_0010, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            apply(st[i]);
            exp_q.push_back(ex[i]);
            @(posedge clk); #1;
            want = exp_q.pop_front();
            got  = sample();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL wrap[%0d] got %h expected %h", i, got, want);
            end
        end
    endtask

    initial begin
        apply(s(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        @(posedge clk); #1;
        test_reset();
        test_sequential();
        test_branch();
        test_jump();
        test_stall();
        test_jr_misalign();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage and IF/ID pipeline register for the MIPS core, directly upstream of the Control unit.
- Holds the PC and drives the instruction-memory address.
- Latches the fetched instruction and PC+4 into IF/ID; id_op feeds Control's OP input.
- Applies redirects resolved in ID (BEQ/BNE, J/JAL, JR), plus stall and flush, to select the next PC.

Parameters:
PC_RESET, 32'h0040_0000, PC value loaded on reset.
NOP_INSTR, 32'h0000_0000, instruction word inserted into IF/ID on flush/reset.

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
stall  in  1  hold PC and IF/ID (load-use hazard)
branch_eq  in  1  BranchEQ from Control for the instruction in ID
branch_ne  in  1  BranchNE from Control for the instruction in ID
zero  in  1  equality compare result of ID operands (1 = equal)
branch_imm  in  32  sign-extended 16-bit immediate of the ID instruction
jump  in  1  J or JAL in ID
jr  in  1  JR in ID
jr_target  in  32  rs value for JR
imem_rdata  in  32  instruction word at imem_addr (combinational read)
imem_addr  out  32  current PC
id_instr  out  32  IF/ID instruction
id_pc4  out  32  IF/ID PC+4
id_op  out  6  id_instr[31:26], to Control OP
id_valid  out  1  IF/ID holds a real instruction
misalign  out  1  sticky: a redirect target had bits [1:0] != 0

Behaviour:
- Clocking and reset: one clock. Reset is synchronous, active-high, sampled on the rising edge of clk.
- Reset values: PC=PC_RESET, id_instr=NOP_INSTR, id_pc4=0, id_valid=0, misalign=0.
- Reset mid-operation overrides stall and all redirects in the same cycle.
- State machine, two states:
  - BOOT: entered on reset. Lasts exactly one cycle. PC advances normally; id_valid is forced to 0 for that capture. Goes to RUN.
  - RUN: steady state. Stays in RUN until reset.
- Latency: instruction at PC appears in id_instr one cycle later. id_op is combinational from id_instr.
- Redirect evaluation applies only when stall=0. Priority, highest first:
  - jr: target = jr_target
  - jump: target = {id_pc4[31:28], id_instr[25:0], 2'b00}
  - taken branch, (branch_eq & zero) | (branch_ne & ~zero): target = id_pc4 + (branch_imm << 2)
  - otherwise sequential: PC+4
- Redirects are ignored when id_valid=0.
- Arithmetic: all additions are 32-bit and wrap modulo 2^32 (PC 32'hFFFF_FFFC + 4 = 0).
- Taken redirect: PC <= target, and IF/ID is flushed the same edge (id_instr=NOP_INSTR, id_valid=0, id_pc4=0). The wrong-path fetch is discarded, giving a one-bubble penalty.
- Misaligned target: bits [1:0] forced to 0 in the loaded PC; misalign set and held until reset.
- Stall=1: PC, id_instr, id_pc4, id_valid all hold. Redirect inputs are ignored for that cycle; Control re-presents them once stall drops.
- Simultaneous jump and branch_eq/ne: jump wins. jr with jump: jr wins.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- When defined: adds outputs perf_fetch_cnt[31:0] and perf_flush_cnt[31:0].
  - perf_fetch_cnt increments on each edge where a valid instruction is captured into IF/ID.
  - perf_flush_cnt increments on each taken redirect.
  - Both clear on reset, hold during stall, and wrap at 2^32.
- When undefined: ports and logic are absent. Core behaviour is identical.

Decomposition:
- Package mips_fetch_pkg:
  - PC_RESET default and NOP_INSTR
  - opcode constants (R_TYPE 6'h00, J 6'h02, JAL 6'h03, BEQ 6'h04, BNE 6'h05)
  - 2-bit redirect-select encoding: SEQ, BR, JMP, JR
  - state encoding: BOOT, RUN
- Sub-module fetch_next_pc: combinational priority mux producing next PC, the redirect flag and the misalign flag. Registers and the FSM stay in fetch_stage.

Test Plan:
- Reset then run 3 cycles with imem_rdata=32'h2008_0005 -> imem_addr 0x00400000, 0x00400004, 0x00400008; id_valid 0 in the first cycle after reset, then 1; id_op=6'h08.
- BEQ in ID (id_pc4=0x00400008, branch_eq=1, zero=1, branch_imm=32'hFFFF_FFFE) -> next imem_addr 0x00400000; id_valid=0 and id_instr=0 the following cycle.
- BNE with zero=1 -> not taken; sequential PC+4, no flush.
- J with id_instr=32'h0810_0004, id_pc4=0x00400010 -> imem_addr 0x00400010. Same cycle with branch_eq=1, zero=1 -> jump still wins.
- stall=1 for 2 cycles with jump asserted -> PC and IF/ID unchanged, no redirect. After stall=0 with jump held -> redirect taken.
- jr_target=32'h0040_0013 -> imem_addr 0x00400010, misalign=1 sticky until reset. Reset asserted during stall -> PC=0x00400000, id_valid=0.
